fifo_rd_stream_adapter: RTL and testbench

//  Downstream neighbour of the sync FIFO. It drains the FIFO read port
//  (read_enable / data_out, 1-cycle read latency) and presents the words as
//  a valid/ready stream. A small credit-tracked output buffer absorbs the

---
 rtl/fifo_common_pkg.sv | 20 ++
 rtl/fifo_skid_buf.sv | 66 ++++++
 rtl/fifo_rd_stream_adapter.sv | 86 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_common_pkg.sv
// Shared definitions for the sync FIFO and its read-side neighbours:
// default word width, word type and the circular-pointer wrap helper.
package fifo_common_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32'd8;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_data_t;

  // Advance a circular index, wrapping depth-1 -> 0 (works for any depth).
  function automatic int unsigned buf_ptr_inc(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt_s;
    if (ptr >= (depth - 32'd1)) begin
      nxt_s = 32'd0;
    end else begin
      nxt_s = ptr + 32'd1;
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular output buffer: push at wr_ptr, pop at rd_ptr, occupancy
// count. The caller guarantees push never targets a full buffer and pop is
// only requested while the buffer holds a word.
module fifo_skid_buf
  import fifo_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = 32'd3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;

  // Next pointer values using the shared wrap rule (handles non-power-of-2 depths).
  always_comb begin
    wr_ptr_nxt_s = PTR_W'(buf_ptr_inc(32'(wr_ptr_r), DEPTH));
    rd_ptr_nxt_s = PTR_W'(buf_ptr_inc(32'(rd_ptr_r), DEPTH));
  end

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_nxt_s;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head word and occupancy straight from the registers.
  always_comb begin
    head  = mem_r[rd_ptr_r];
    count = count_r;
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains the sync FIFO read port (1-cycle read latency) into a valid/ready
// stream. Reads are issued only against free buffer credit, counting the
// in-flight word as reserved, so captures never overflow and m_ready has
// no combinational path to the FIFO.
// Optional feature macro: FIFO_RD_CNT_EN adds the xfer_count output.
module fifo_rd_stream_adapter
  import fifo_common_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = 32'd3,
  parameter int unsigned CNT_WIDTH  = 32'd16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 32'd1);

  logic             inflight_r;
  logic [CNT_W-1:0] buf_count_s;
  logic [CNT_W:0]   credit_used_s;
  logic             pop_s;

  // Issue a read only when the FIFO has data and buffer plus in-flight leaves a free slot.
  always_comb begin
    credit_used_s    = {1'b0, buf_count_s} + {{CNT_W{1'b0}}, inflight_r};
    fifo_read_enable = rst_n & ~fifo_empty & (credit_used_s < (CNT_W + 1)'(BUF_DEPTH));
    m_valid          = (buf_count_s != '0);
    pop_s            = m_valid & m_ready;
  end

  // A strobe this clock means the FIFO presents a word next clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= fifo_read_enable;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (fifo_data_out),
    .pop       (pop_s),
    .head      (m_data),
    .count     (buf_count_s)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] xfer_count_r;

  // Count accepted stream words, wrapping naturally at 2**CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_r <= '0;
    end else if (pop_s) begin
      xfer_count_r <= xfer_count_r + CNT_WIDTH'(1);
    end else begin
      xfer_count_r <= xfer_count_r;
    end
  end

  // Drive the counter port from its register.
  always_comb begin
    xfer_count = xfer_count_r;
  end
`else
  localparam int unsigned CNT_WIDTH_UNUSED = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter: a behavioural sync FIFO
// feeds the DUT, a scoreboard queue holds the words expected on the stream,
// a table drives the back-pressure cases, hand sequences cover the corners.
module tb_fifo_rd_stream_adapter;
  import fifo_common_pkg::*;

  localparam int DW = 8;
  localparam int BD = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_data_out;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] xfer_count;
`endif

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int empty_strobes = 0;
  int accepted = 0;

  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;
  fifo_data_t  mem [64];
  fifo_data_t  exp_q [$];

  typedef struct {
    int   nwords;
    int   exp_strobes;
    logic exp_valid;
  } stall_vec_t;
  stall_vec_t vecs [4];

  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_data_out    (fifo_data_out),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .xfer_count       (xfer_count)
`endif
  );

  // Behavioural sync FIFO: data one clock after the strobe, emptied by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx        <= wr_idx;
      fifo_data_out <= '0;
    end else if (fifo_read_enable) begin
      fifo_data_out <= mem[rd_idx % 64];
      rd_idx        <= rd_idx + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Strobe counter and empty-read detector.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && fifo_read_enable) begin
        strobes++;
        if (fifo_empty) empty_strobes++;
      end
    end
  end

  // Stream monitor: a handshake seen at negedge completes at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_word", 32'(m_data), 32'(exp_q.pop_front()));
        end
        accepted++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic load(input fifo_data_t w);
    mem[wr_idx % 64] = w;
    wr_idx++;
    exp_q.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    accepted = 0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic simul_round(input fifo_data_t w, input int exp_wr, input int exp_rd);
    load(w);
    tick(1);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("simul_count", 32'(dut.u_buf.count_r), 32'd2);
    chk("simul_wr_ptr", 32'(dut.u_buf.wr_ptr_r), 32'(exp_wr));
    chk("simul_rd_ptr", 32'(dut.u_buf.rd_ptr_r), 32'(exp_rd));
  endtask

  initial begin
    int s0;
    vecs[0] = '{nwords: 0, exp_strobes: 0, exp_valid: 1'b0};
    vecs[1] = '{nwords: 1, exp_strobes: 1, exp_valid: 1'b1};
    vecs[2] = '{nwords: 2, exp_strobes: 2, exp_valid: 1'b1};
    vecs[3] = '{nwords: 5, exp_strobes: 3, exp_valid: 1'b1};

    // Reset: FIFO non-empty but no strobe while rst_n is low.
    tick(2);
    load(8'hA5);
    #1;
    chk("rst_fifo_nonempty", 32'(fifo_empty), 32'd0);
    chk("rst_read_enable", 32'(fifo_read_enable), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("release_strobe", 32'(fifo_read_enable), 32'd1);
    tick(3);
    chk("first_word_valid", 32'(m_valid), 32'd1);
    chk("first_word_data", 32'(m_data), 32'hA5);
    m_ready = 1'b1;
    tick(2);
    m_ready = 1'b0;
    chk("first_word_gone", 32'(m_valid), 32'd0);

    // Stream: 10 words, 2-clk latency then one word per clock.
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) load(fifo_data_t'(i));
    #1;
    chk("stream_strobe_now", 32'(fifo_read_enable), 32'd1);
    @(negedge clk);
    chk("stream_lat_n", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("stream_lat_n1", 32'(m_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_b2b_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    chk("stream_end_valid", 32'(m_valid), 32'd0);
    chk("stream_all_out", 32'(exp_q.size()), 32'd0);
    #6;

    // Back-pressure table: m_ready low for 20 clocks, then drain.
    for (int k = 0; k < 4; k++) begin
      fifo_data_t base;
      base = fifo_data_t'(8'h40 + 8'(16 * k));
      do_reset();
      s0 = strobes;
      for (int i = 0; i < vecs[k].nwords; i++) load(base + fifo_data_t'(i));
      tick(5);
      if (vecs[k].exp_valid) chk("stall_data_early", 32'(m_data), 32'(base));
      tick(15);
      chk("stall_strobes", 32'(strobes - s0), 32'(vecs[k].exp_strobes));
      chk("stall_count", 32'(dut.u_buf.count_r), 32'(vecs[k].exp_strobes));
      chk("stall_valid", 32'(m_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) chk("stall_data_late", 32'(m_data), 32'(base));
      m_ready = 1'b1;
      tick(vecs[k].nwords + 6);
      m_ready = 1'b0;
      chk("stall_drained", 32'(exp_q.size()), 32'd0);
    end

    // Empty edge: one word gives exactly one strobe; m_valid drops after its pop.
    do_reset();
    m_ready = 1'b1;
    s0 = strobes;
    load(8'h77);
    tick(8);
    chk("single_strobe", 32'(strobes - s0), 32'd1);
    chk("single_valid_low", 32'(m_valid), 32'd0);
    chk("single_popped", 32'(exp_q.size()), 32'd0);

    // Simultaneous capture and pop at count=2 across pointer wrap.
    do_reset();
    load(8'hC0);
    load(8'hC1);
    tick(4);
    chk("simul_pre_count", 32'(dut.u_buf.count_r), 32'd2);
    simul_round(8'hC2, 0, 1);
    simul_round(8'hC3, 1, 2);
    simul_round(8'hC4, 2, 0);
    m_ready = 1'b1;
    tick(5);
    m_ready = 1'b0;
    chk("simul_drained", 32'(exp_q.size()), 32'd0);

    // Mid-operation reset after 4 pops with 2 words buffered.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) load(fifo_data_t'(8'h90 + 8'(i)));
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (accepted >= 4) begin
        m_ready = 1'b0;
        break;
      end
    end
    tick(4);
    chk("midrst_pops", 32'(accepted), 32'd4);
    chk("midrst_buffered", 32'(dut.u_buf.count_r), 32'd2);
    rst_n = 1'b0;
    exp_q.delete();
    accepted = 0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_read_enable", 32'(fifo_read_enable), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("midrst_xfer_count", 32'(xfer_count), 32'd0);
`endif
    tick(2);
    rst_n = 1'b1;

    // Random traffic with random back-pressure.
    for (int c = 0; c < 2000; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && (wr_idx - rd_idx) < 50) load(fifo_data_t'($urandom_range(0, 255)));
      tick(1);
    end
    m_ready = 1'b1;
    tick(80);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_valid_idle", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rand_xfer_count", 32'(xfer_count), 32'(accepted[CW-1:0]));
`endif
    chk("no_strobe_when_empty", 32'(empty_strobes), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
